// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the core's load/store port. Accepts one request
//   at a time over a valid/ready handshake, waits WAIT_CYCLES cycles, performs a
//   byte/half/word access on an internal little-endian word array and returns a
//   one-cycle response carrying load data or an error flag.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (byte addresses 0 .. 4*DEPTH_WORDS-1)
//   WAIT_CYCLES  wait states between accept and access (0..15)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   req_valid   in   initiator presents a request
//   req_ready   out  high only in IDLE (and never while reset is asserted)
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_size    in   funct3 size code (B/H/W/BU/HU)
//   req_wdata   in   right-aligned store data
//   resp_valid  out  one-cycle response strobe
//   resp_rdata  out  extended load data; 0 for stores and errors
//   resp_err    out  request rejected (misaligned / out of range / bad size)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          req_err;
  logic          do_access;
  logic          acc_write;
  logic [AW+1:0] acc_addr;
  logic [2:0]    acc_size;
  logic [31:0]   acc_wdata;
  logic [31:0]   rd_word;
  logic [31:0]   st_word;
  logic [31:0]   ld_data;

  // ---------------------------------------------------------------------------
  // Request legality: alignment, range and size code (store sizes are B/H/W).
  // ---------------------------------------------------------------------------
  function automatic logic calc_err(input logic wr, input logic [31:0] a,
                                    input logic [2:0] sz);
    logic e;
    e = ({1'b0, a} >= ADDR_LIMIT);
    case (sz)
      SZ_B:    ;
      SZ_H:    if (a[0]) e = 1'b1;
      SZ_W:    if (a[1:0] != 2'b00) e = 1'b1;
      SZ_BU:   if (wr) e = 1'b1;
      SZ_HU:   if (wr || a[0]) e = 1'b1;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Lane extraction: shift the addressed lane down to bit 0, then extend.
  function automatic logic [31:0] load_data(input logic [31:0] word,
                                            input logic [1:0] lo,
                                            input logic [2:0] sz);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lo, 3'b000};
    case (sz)
      SZ_B:    r = {{24{sh[7]}}, sh[7:0]};
      SZ_H:    r = {{16{sh[15]}}, sh[15:0]};
      SZ_W:    r = sh;
      SZ_BU:   r = {24'h0, sh[7:0]};
      SZ_HU:   r = {16'h0, sh[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Byte-lane merge: replicate the store data across lanes, enable only the
  // addressed lane(s), keep the rest of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [1:0] lo,
                                              input logic [2:0] sz,
                                              input logic [31:0] wd);
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] r;
    case (sz)
      SZ_B: begin
        be = 4'b0001 << lo;
        d  = {4{wd[7:0]}};
      end
      SZ_H: begin
        be = 4'b0011 << {lo[1], 1'b0};
        d  = {2{wd[15:0]}};
      end
      default: begin
        be = 4'b1111;
        d  = wd;
      end
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  assign accept  = req_valid & req_ready;
  assign req_err = calc_err(req_write, req_addr, req_size);

  // With WAIT_CYCLES == 0 the access happens on the accept edge itself, so the
  // access path reads the live request in IDLE and the latched copy in WAIT.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_size  = size_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr[AW+1:0];
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end
  end

  assign do_access = (state_q == S_IDLE) ? (accept && !req_err && (WAIT_CYCLES == 0))
                                         : ((state_q == S_WAIT) && (cnt_q == '0));

  assign rd_word = mem_q[acc_addr[AW+1:2]];
  assign st_word = store_merge(rd_word, acc_addr[1:0], acc_size, acc_wdata);
  assign ld_data = load_data(rd_word, acc_addr[1:0], acc_size);

  // Array contents are not reset; a store only commits on its access edge.
  always_ff @(posedge clk) begin
    if (rst && do_access && acc_write) begin
      mem_q[acc_addr[AW+1:2]] <= st_word;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr[AW+1:0];
          size_d  = req_size;
          wdata_d = req_wdata;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            err_d   = 1'b0;
            rdata_d = acc_write ? '0 : ld_data;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          err_d   = 1'b0;
          rdata_d = acc_write ? '0 : ld_data;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (response fields are only driven during RESP)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state_q)
      S_IDLE: req_ready = rst;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Two instances share the request bus:
//   dut_a (WAIT_CYCLES=2) and dut_b (WAIT_CYCLES=0); `sel` routes req_valid and
//   selects which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;

  logic        va, vb;
  logic        a_ready, a_rv, a_err;
  logic [31:0] a_rd;
  logic        b_ready, b_rv, b_err;
  logic [31:0] b_rd;
  logic        ready, rv, err;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign va    = req_valid & ~sel;
  assign vb    = req_valid & sel;
  assign ready = sel ? b_ready : a_ready;
  assign rv    = sel ? b_rv    : a_rv;
  assign rd    = sel ? b_rd    : a_rd;
  assign err   = sel ? b_err   : a_err;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(b_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .resp_valid(b_rv), .resp_rdata(b_rd), .resp_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge and hold it through one rising edge.
  task automatic issue(input string tag, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    chk({tag, "/ready_idle"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count falling edges from the accept edge to resp_valid; inputs are
  // scrambled (with valid low) while waiting so they must not reach the access.
  task automatic await_resp(input string tag, input int exp_lat,
                            input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 16) begin
      @(negedge clk);
      n++;
      if (rv) begin
        found = 1'b1;
      end else begin
        chk({tag, "/ready_busy"}, 32'(ready), 32'd0);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'b1;
        req_size  = 3'($urandom_range(7, 0));
      end
    end
    chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
    if (found) begin
      chk({tag, "/rdata"}, rd, exp_rd);
      chk({tag, "/err"}, 32'(err), 32'(exp_err));
      chk({tag, "/ready_resp"}, 32'(ready), 32'd0);
    end
    @(negedge clk);
    chk({tag, "/valid_drop"}, 32'(rv), 32'd0);
    chk({tag, "/rdata_drop"}, rd, 32'd0);
    chk({tag, "/err_drop"}, 32'(err), 32'd0);
    chk({tag, "/ready_back"}, 32'(ready), 32'd1);
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd, input int lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    issue(tag, w, a, sz, wd);
    await_resp(tag, lat, exp_rd, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;

    // Reset state
    #12;
    chk("rst/ready", 32'(ready), 32'd0);
    chk("rst/valid", 32'(rv), 32'd0);
    chk("rst/rdata", rd, 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst/ready_idle", 32'(ready), 32'd1);

    // 1. word store then load
    xfer("t1_sw", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 3, 32'h0, 1'b0);
    xfer("t1_lw", 1'b0, 32'h10, 3'b010, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    // 2. sub-word lanes and extension
    xfer("t2_sb",   1'b1, 32'h11, 3'b000, 32'hFFFFFF80, 3, 32'h0, 1'b0);
    xfer("t2_lb",   1'b0, 32'h11, 3'b000, 32'h0, 3, 32'hFFFFFF80, 1'b0);
    xfer("t2_lbu",  1'b0, 32'h11, 3'b100, 32'h0, 3, 32'h00000080, 1'b0);
    xfer("t2_lw1",  1'b0, 32'h10, 3'b010, 32'h0, 3, 32'hDEAD80EF, 1'b0);
    xfer("t2_sh",   1'b1, 32'h12, 3'b001, 32'hABCD1234, 3, 32'h0, 1'b0);
    xfer("t2_lhu",  1'b0, 32'h12, 3'b101, 32'h0, 3, 32'h00001234, 1'b0);
    xfer("t2_lh",   1'b0, 32'h12, 3'b001, 32'h0, 3, 32'h00001234, 1'b0);
    xfer("t2_lb3",  1'b0, 32'h13, 3'b000, 32'h0, 3, 32'h00000012, 1'b0);
    xfer("t2_lh0",  1'b0, 32'h10, 3'b001, 32'h0, 3, 32'hFFFF80EF, 1'b0);
    xfer("t2_lw2",  1'b0, 32'h10, 3'b010, 32'h0, 3, 32'h123480EF, 1'b0);

    // 3. misaligned / illegal size: error after one cycle, no write
    xfer("t3_lh_mis",  1'b0, 32'h13, 3'b001, 32'h0, 1, 32'h0, 1'b1);
    xfer("t3_sw_mis",  1'b1, 32'h12, 3'b010, 32'h0, 1, 32'h0, 1'b1);
    xfer("t3_lw_keep", 1'b0, 32'h10, 3'b010, 32'h0, 3, 32'h123480EF, 1'b0);
    xfer("t3_st_sz4",  1'b1, 32'h10, 3'b100, 32'h0, 1, 32'h0, 1'b1);
    xfer("t3_ld_sz3",  1'b0, 32'h10, 3'b011, 32'h0, 1, 32'h0, 1'b1);
    xfer("t3_lw_keep2", 1'b0, 32'h10, 3'b010, 32'h0, 3, 32'h123480EF, 1'b0);

    // 4. address range boundary
    xfer("t4_lw_oor", 1'b0, 32'h400, 3'b010, 32'h0, 1, 32'h0, 1'b1);
    xfer("t4_sw_top", 1'b1, 32'h3FC, 3'b010, 32'h5A5A1234, 3, 32'h0, 1'b0);
    xfer("t4_lw_top", 1'b0, 32'h3FC, 3'b010, 32'h0, 3, 32'h5A5A1234, 1'b0);
    xfer("t4_sb_oor", 1'b1, 32'h400, 3'b000, 32'h77, 1, 32'h0, 1'b1);
    xfer("t4_lw_top2", 1'b0, 32'h3FC, 3'b010, 32'h0, 3, 32'h5A5A1234, 1'b0);

    // 5. req_valid held high; address changes while busy are ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h10;
    chk("t5/ready_idle", 32'(ready), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk("t5/ready_busy", 32'(ready), 32'd0);
      if (n < 3) begin
        chk("t5/valid_wait", 32'(rv), 32'd0);
        req_addr = (n == 1) ? 32'h14 : 32'h3FC;
      end else begin
        chk("t5/valid_resp", 32'(rv), 32'd1);
        chk("t5/rdata", rd, 32'h123480EF);
      end
    end
    @(negedge clk);
    chk("t5/ready_again", 32'(ready), 32'd1);
    chk("t5/valid_gap", 32'(rv), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    await_resp("t5_second", 3, 32'h5A5A1234, 1'b0);

    // 6. reset during WAIT discards a pending store
    xfer("t6_sw", 1'b1, 32'h20, 3'b010, 32'h11223344, 3, 32'h0, 1'b0);
    xfer("t6_lw", 1'b0, 32'h20, 3'b010, 32'h0, 3, 32'h11223344, 1'b0);
    issue("t6_sw_abort", 1'b1, 32'h20, 3'b010, 32'hAAAAAAAA);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6/ready_rst", 32'(ready), 32'd0);
    chk("t6/valid_rst", 32'(rv), 32'd0);
    chk("t6/rdata_rst", rd, 32'd0);
    chk("t6/err_rst", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t6/ready_rel", 32'(ready), 32'd1);
    xfer("t6_lw_after", 1'b0, 32'h20, 3'b010, 32'h0, 3, 32'h11223344, 1'b0);

    // 6b. WAIT_CYCLES=0 instance: single-cycle latency
    sel = 1'b1;
    xfer("b_sw",   1'b1, 32'h8, 3'b010, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    xfer("b_lw",   1'b0, 32'h8, 3'b010, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    xfer("b_lhu",  1'b0, 32'h9, 3'b101, 32'h0, 1, 32'h0, 1'b1);
    xfer("b_lb",   1'b0, 32'hB, 3'b000, 32'h0, 1, 32'hFFFFFFCA, 1'b0);
    xfer("b_lhu2", 1'b0, 32'hA, 3'b101, 32'h0, 1, 32'h0000CAFE, 1'b0);
    issue("b_sw0", 1'b1, 32'h8, 3'b010, 32'h0);
    chk("b/valid_resp", 32'(rv), 32'd1);
    rst = 1'b0;
    #1;
    chk("b/valid_rst", 32'(rv), 32'd0);
    chk("b/rdata_rst", rd, 32'd0);
    chk("b/ready_rst", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    xfer("b_lw_after", 1'b0, 32'h8, 3'b010, 32'h0, 1, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
